seg_capture_decoder: RTL and testbench

//  Receive side of the 7-segment interface: snoops a multiplexed display bus (segment lines + digit

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_pattern_decode.sv | 35 +++
 rtl/seg_capture_decoder.sv | 129 ++++++++++++
 tb/tb_seg_capture_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph patterns (a..g, bit0 = a) and the decoded result type.
// Used by both the encoder and the capture decoder so the two cannot drift apart.
package seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 4;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

    typedef struct packed {
        logic             valid;
        logic [DIG_W-1:0] value;
    } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern -> {valid, value} decoder (exact match only).
// SEG_CAPT_HEX_EN: when defined, the A..F glyphs also decode as 0xA..0xF.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] i_pat,
    output seg_dec_t         o_dec
);

    always_comb begin
        o_dec = '{valid: 1'b0, value: '0};
        case (i_pat)
            GLYPH_0: o_dec = '{valid: 1'b1, value: 4'h0};
            GLYPH_1: o_dec = '{valid: 1'b1, value: 4'h1};
            GLYPH_2: o_dec = '{valid: 1'b1, value: 4'h2};
            GLYPH_3: o_dec = '{valid: 1'b1, value: 4'h3};
            GLYPH_4: o_dec = '{valid: 1'b1, value: 4'h4};
            GLYPH_5: o_dec = '{valid: 1'b1, value: 4'h5};
            GLYPH_6: o_dec = '{valid: 1'b1, value: 4'h6};
            GLYPH_7: o_dec = '{valid: 1'b1, value: 4'h7};
            GLYPH_8: o_dec = '{valid: 1'b1, value: 4'h8};
            GLYPH_9: o_dec = '{valid: 1'b1, value: 4'h9};
`ifdef SEG_CAPT_HEX_EN
            GLYPH_A: o_dec = '{valid: 1'b1, value: 4'hA};
            GLYPH_B: o_dec = '{valid: 1'b1, value: 4'hB};
            GLYPH_C: o_dec = '{valid: 1'b1, value: 4'hC};
            GLYPH_D: o_dec = '{valid: 1'b1, value: 4'hD};
            GLYPH_E: o_dec = '{valid: 1'b1, value: 4'hE};
            GLYPH_F: o_dec = '{valid: 1'b1, value: 4'hF};
`endif
            default: o_dec = '{valid: 1'b0, value: '0};
        endcase
    end

endmodule

// File: rtl/seg_capture_decoder.sv
// Snoops a multiplexed 7-segment bus, decodes each digit and commits it after STABLE_CNT
// identical scans. SEG_CAPT_HEX_EN (see seg_pattern_decode) enables hex glyph decoding.
module seg_capture_decoder
    import seg_pkg::*;
#(
    parameter int unsigned NDIG           = 4,
    parameter int unsigned STABLE_CNT     = 3,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg,
    input  logic [NDIG-1:0]       an,
    input  logic                  err_clr,
    output logic [DIG_W*NDIG-1:0] digits,
    output logic                  upd,
    output logic                  err
);

    localparam logic [DIG_W-1:0] StableMax = DIG_W'(STABLE_CNT);

    logic [NDIG-1:0]  r_s1_an;
    logic [NDIG-1:0]  r_s2_an;
    logic [SEG_W-1:0] r_s1_seg;
    logic [SEG_W-1:0] r_s2_seg;
    logic             r_upd;
    logic             r_err;

    logic             w_unused_dp;
    logic             w_s2_onehot;
    logic             w_slot_end;
    logic [SEG_W-1:0] w_pat;
    seg_dec_t         w_dec;
    logic [NDIG-1:0]  w_commit;
    logic [NDIG-1:0]  w_inval;

    assign w_unused_dp = seg[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_an  <= '0;
            r_s2_an  <= '0;
            r_s1_seg <= '0;
            r_s2_seg <= '0;
        end else begin
            r_s1_an  <= an;
            r_s2_an  <= r_s1_an;
            r_s1_seg <= seg[SEG_W-1:0];
            r_s2_seg <= r_s1_seg;
        end
    end

    // A slot is observed once, on the cycle its anode pattern is about to be replaced.
    assign w_s2_onehot = (r_s2_an != '0) && ((r_s2_an & (r_s2_an - NDIG'(1))) == '0);
    assign w_slot_end  = (r_s1_an != r_s2_an);
    assign w_pat       = (SEG_ACTIVE_LOW != 0) ? ~r_s2_seg : r_s2_seg;

    seg_pattern_decode u_decode (
        .i_pat (w_pat),
        .o_dec (w_dec)
    );

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        logic [DIG_W-1:0] r_cand;
        logic [DIG_W-1:0] r_cnt;
        logic [DIG_W-1:0] r_dig;
        logic             w_obs;
        logic [DIG_W-1:0] w_cand_d;
        logic [DIG_W-1:0] w_cnt_d;

        assign w_obs = w_s2_onehot && w_slot_end && r_s2_an[d];

        always_comb begin
            w_cand_d = r_cand;
            w_cnt_d  = r_cnt;
            if (w_obs) begin
                if (w_dec.valid) begin
                    if ((w_dec.value == r_cand) && (r_cnt != '0)) begin
                        w_cnt_d = (r_cnt >= StableMax) ? StableMax : r_cnt + DIG_W'(1);
                    end else begin
                        w_cand_d = w_dec.value;
                        w_cnt_d  = DIG_W'(1);
                    end
                end else begin
                    w_cnt_d = '0;
                end
            end
        end

        // Saturated repeats of the committed value do not re-commit.
        assign w_commit[d] = w_obs && w_dec.valid && (w_cnt_d == StableMax) && (w_cand_d != r_dig);
        assign w_inval[d]  = w_obs && !w_dec.valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cand <= '0;
                r_cnt  <= '0;
                r_dig  <= '0;
            end else begin
                r_cand <= w_cand_d;
                r_cnt  <= w_cnt_d;
                if (w_commit[d]) begin
                    r_dig <= w_cand_d;
                end
            end
        end

        assign digits[DIG_W*d +: DIG_W] = r_dig;
    end

    // Setting wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_upd <= |w_commit;
            if (|w_inval) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign upd = r_upd;
    assign err = r_err;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed bench for seg_capture_decoder: an active-high and an active-low instance share the scan.
module tb_seg_capture_decoder;
    import seg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic [7:0]  seg;
    logic [7:0]  seg_n;
    logic [3:0]  an;
    logic [15:0] digits_a;
    logic [15:0] digits_b;
    logic        upd_a;
    logic        upd_b;
    logic        err_a;
    logic        err_b;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt_a = 0;
    int upd_cnt_b = 0;
    int base_a;
    int base_b;

    always #5 clk = ~clk;

    seg_capture_decoder #(
        .NDIG           (4),
        .STABLE_CNT     (3),
        .SEG_ACTIVE_LOW (0)
    ) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .an      (an),
        .err_clr (err_clr),
        .digits  (digits_a),
        .upd     (upd_a),
        .err     (err_a)
    );

    seg_capture_decoder #(
        .NDIG           (4),
        .STABLE_CNT     (3),
        .SEG_ACTIVE_LOW (1)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg_n),
        .an      (an),
        .err_clr (err_clr),
        .digits  (digits_b),
        .upd     (upd_b),
        .err     (err_b)
    );

    // upd is read before the edge updates it, so each high cycle is counted once.
    always @(posedge clk) begin
        if (upd_a) upd_cnt_a++;
        if (upd_b) upd_cnt_b++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic slot(input logic [3:0] a, input logic [6:0] p, input int n);
        an    = a;
        seg   = {1'b0, p};
        seg_n = ~{1'b0, p};
        tick(n);
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        slot(4'b0001, p0, 8);
        slot(4'b0010, p1, 8);
        slot(4'b0100, p2, 8);
        slot(4'b1000, p3, 8);
        slot(4'b0000, 7'h00, 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an  = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic mark();
        base_a = upd_cnt_a;
        base_b = upd_cnt_b;
    endtask

    initial begin
        rst     = 1'b1;
        err_clr = 1'b0;
        an      = '0;
        seg     = '0;
        seg_n   = '1;
        tick(3);
        check_eq("reset digits", 32'(digits_a), 32'h0);
        check_eq("reset upd", 32'(upd_a), 32'h0);
        check_eq("reset err", 32'(err_a), 32'h0);
        rst = 1'b0;
        tick(2);

        // 1: digits 1,2,3,4 for three frames
        mark();
        frame(GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4);
        frame(GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4);
        check_eq("t1 digits after 2 frames", 32'(digits_a), 32'h0);
        check_eq("t1 upd after 2 frames", 32'(upd_cnt_a - base_a), 32'd0);
        frame(GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4);
        tick(2);
        check_eq("t1 digits", 32'(digits_a), 32'h4321);
        check_eq("t1 upd count", 32'(upd_cnt_a - base_a), 32'd4);
        check_eq("t1 err", 32'(err_a), 32'h0);
        check_eq("t1 active-low digits", 32'(digits_b), 32'h4321);
        check_eq("t1 active-low upd count", 32'(upd_cnt_b - base_b), 32'd4);

        // 2: digit0 alternates 1/2 so its filter never reaches 3
        do_reset();
        mark();
        for (int f = 0; f < 4; f++) begin
            frame((f % 2 == 0) ? GLYPH_1 : GLYPH_2, GLYPH_0, GLYPH_0, GLYPH_0);
        end
        tick(2);
        check_eq("t2 digits", 32'(digits_a), 32'h0);
        check_eq("t2 upd count", 32'(upd_cnt_a - base_a), 32'd0);
        check_eq("t2 err", 32'(err_a), 32'h0);

        // 3: hex glyph A on digit2
        do_reset();
        mark();
        for (int f = 0; f < 3; f++) frame(GLYPH_0, GLYPH_0, GLYPH_A, GLYPH_0);
        tick(2);
`ifdef SEG_CAPT_HEX_EN
        check_eq("t3 digits hex", 32'(digits_a), 32'h0A00);
        check_eq("t3 upd count hex", 32'(upd_cnt_a - base_a), 32'd1);
        check_eq("t3 err hex", 32'(err_a), 32'h0);
`else
        check_eq("t3 digits", 32'(digits_a), 32'h0);
        check_eq("t3 upd count", 32'(upd_cnt_a - base_a), 32'd0);
        check_eq("t3 err", 32'(err_a), 32'h1);
        check_eq("t3 active-low err", 32'(err_b), 32'h1);
`endif
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check_eq("t3 err after clear", 32'(err_a), 32'h0);

        // err_clr on the same edge as an invalid observation: set wins
        slot(4'b0100, 7'h00, 8);
        slot(4'b0000, 7'h00, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check_eq("t3 set wins over clear", 32'(err_a), 32'h1);
        tick(1);
        check_eq("t3 err sticky", 32'(err_a), 32'h1);

        // 4: multi-hot and idle anodes between slots carry an invalid pattern
        do_reset();
        mark();
        for (int f = 0; f < 3; f++) begin
            slot(4'b0001, GLYPH_5, 8);
            slot(4'b0011, 7'h00, 8);
            slot(4'b0010, GLYPH_6, 8);
            slot(4'b0000, 7'h00, 8);
            slot(4'b0100, GLYPH_7, 8);
            slot(4'b0011, 7'h00, 8);
            slot(4'b1000, GLYPH_8, 8);
            slot(4'b0000, 7'h00, 4);
        end
        tick(2);
        check_eq("t4 digits", 32'(digits_a), 32'h8765);
        check_eq("t4 err", 32'(err_a), 32'h0);
        check_eq("t4 upd count", 32'(upd_cnt_a - base_a), 32'd4);

        // 5: active-low instance sees zeros on every digit
        do_reset();
        mark();
        for (int f = 0; f < 3; f++) frame(GLYPH_0, GLYPH_0, GLYPH_0, GLYPH_0);
        tick(2);
        check_eq("t5 active-low digits", 32'(digits_b), 32'h0);
        check_eq("t5 active-low upd count", 32'(upd_cnt_b - base_b), 32'd0);
        check_eq("t5 active-low err", 32'(err_b), 32'h0);

        // 6: reset mid-frame after two stable frames of 7
        do_reset();
        frame(GLYPH_7, GLYPH_7, GLYPH_7, GLYPH_7);
        frame(GLYPH_7, GLYPH_7, GLYPH_7, GLYPH_7);
        slot(4'b0001, GLYPH_7, 3);
        rst = 1'b1;
        tick(2);
        an  = '0;
        rst = 1'b0;
        tick(1);
        check_eq("t6 digits after reset", 32'(digits_a), 32'h0);
        check_eq("t6 upd after reset", 32'(upd_a), 32'h0);
        check_eq("t6 err after reset", 32'(err_a), 32'h0);
        tick(2);
        mark();
        frame(GLYPH_7, GLYPH_7, GLYPH_7, GLYPH_7);
        frame(GLYPH_7, GLYPH_7, GLYPH_7, GLYPH_7);
        tick(2);
        check_eq("t6 digits after 2 frames", 32'(digits_a), 32'h0);
        check_eq("t6 upd after 2 frames", 32'(upd_cnt_a - base_a), 32'd0);
        frame(GLYPH_7, GLYPH_7, GLYPH_7, GLYPH_7);
        tick(2);
        check_eq("t6 digits", 32'(digits_a), 32'h7777);
        check_eq("t6 upd count", 32'(upd_cnt_a - base_a), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
